// File: rtl/fsm_check_pkg.sv
// Shared types and default widths for the FSM step checker.
package fsm_check_pkg;

    localparam int STATE_W_DEF = 3;
    localparam int DEPTH_DEF   = 8;
    localparam int CNT_W_DEF   = 8;

    // One expected observation: FSM state and out after a step.
    typedef struct packed {
        logic [STATE_W_DEF-1:0] state;
        logic                   out;
    } exp_entry_t;

    // Control FSM: IDLE = nothing pending, CMP = compare at this edge,
    // HALT = stopped after first failure (stop-on-error builds only).
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        HALT = 2'd2
    } chk_state_t;

endpackage

// File: rtl/fsm_exp_fifo.sv
// Synchronous FIFO holding expected entries; reset flushes it.
module fsm_exp_fifo
    import fsm_check_pkg::*;
#(
    parameter int  DEPTH   = DEPTH_DEF,
    parameter type entry_t = exp_entry_t
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   push,
    input  logic   pop,
    input  entry_t wr_data,
    output entry_t rd_data,
    output logic   full,
    output logic   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   CNT_ONE = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   CNT_FULL = {1'b1, {PTR_W{1'b0}}};

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    entry_t           mem_r [DEPTH];
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CNT_FULL);
    assign empty     = (count_r == {(PTR_W+1){1'b0}});
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign rd_data   = mem_r[rd_ptr_r];

    // Storage array; written only on an accepted push.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/fsm_step_checker.sv
// Scoreboard stage comparing an FSM's registered state/out against a queue
// of expected entries, one compare per step strobe.
// Optional build macro: STOP_ON_ERR_EN (halt checking on the first failure).
module fsm_step_checker
    import fsm_check_pkg::*;
#(
    parameter int STATE_W = STATE_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               exp_valid,
    output logic               exp_ready,
    input  logic [STATE_W-1:0] exp_state,
    input  logic               exp_out,
    input  logic               step_in,
    input  logic [STATE_W-1:0] dut_state,
    input  logic               dut_out,
    output logic               mismatch,
    output logic [CNT_W-1:0]   err_count,
    output logic [CNT_W-1:0]   step_count,
    output logic [CNT_W-1:0]   first_err_idx,
    output logic               err_seen,
    output logic               underflow,
    output logic               halted
);

    typedef struct packed {
        logic [STATE_W-1:0] state;
        logic               out;
    } chk_entry_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_ONE;
        end
    endfunction

    chk_state_t     state_r;
    chk_state_t     state_nxt_s;
    chk_entry_t     push_data_s;
    chk_entry_t     head_s;
    logic           full_s;
    logic           empty_s;
    logic           push_s;
    logic           cmp_s;
    logic           pop_s;
    logic           fail_s;
    logic           mismatch_r;
    logic [CNT_W-1:0] err_count_r;
    logic [CNT_W-1:0] step_count_r;
    logic [CNT_W-1:0] first_err_idx_r;
    logic           err_seen_r;
    logic           underflow_r;

`ifdef STOP_ON_ERR_EN
    assign halted = (state_r == HALT);
`else
    assign halted = 1'b0;
`endif

    assign exp_ready         = !full_s && !halted;
    assign push_s            = exp_valid && exp_ready;
    assign push_data_s.state = exp_state;
    assign push_data_s.out   = exp_out;
    assign cmp_s             = (state_r == CMP);
    assign pop_s             = cmp_s && !empty_s;
    assign fail_s            = pop_s && ((head_s.state != dut_state) || (head_s.out != dut_out));

    fsm_exp_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (chk_entry_t)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_s),
        .pop     (pop_s),
        .wr_data (push_data_s),
        .rd_data (head_s),
        .full    (full_s),
        .empty   (empty_s)
    );

    // Control FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state: track the step strobe one cycle late; halt on failure if enabled.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (step_in) begin
                    state_nxt_s = CMP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CMP: begin
`ifdef STOP_ON_ERR_EN
                if (fail_s) begin
                    state_nxt_s = HALT;
                end else if (step_in) begin
                    state_nxt_s = CMP;
                end else begin
                    state_nxt_s = IDLE;
                end
`else
                if (step_in) begin
                    state_nxt_s = CMP;
                end else begin
                    state_nxt_s = IDLE;
                end
`endif
            end
            HALT: begin
`ifdef STOP_ON_ERR_EN
                state_nxt_s = HALT;
`else
                state_nxt_s = IDLE;
`endif
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Compare results, saturating counters and sticky flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mismatch_r      <= 1'b0;
            err_count_r     <= CNT_ZERO;
            step_count_r    <= CNT_ZERO;
            first_err_idx_r <= CNT_ZERO;
            err_seen_r      <= 1'b0;
            underflow_r     <= 1'b0;
        end else begin
            mismatch_r <= fail_s;
            if (pop_s) begin
                step_count_r <= sat_inc(step_count_r);
            end
            if (fail_s) begin
                err_count_r <= sat_inc(err_count_r);
                if (!err_seen_r) begin
                    err_seen_r      <= 1'b1;
                    first_err_idx_r <= step_count_r;
                end
            end
            if (cmp_s && empty_s) begin
                underflow_r <= 1'b1;
            end
        end
    end

    assign mismatch      = mismatch_r;
    assign err_count     = err_count_r;
    assign step_count    = step_count_r;
    assign first_err_idx = first_err_idx_r;
    assign err_seen      = err_seen_r;
    assign underflow     = underflow_r;

endmodule

// File: doc/fsm_step_checker.md
# fsm_step_checker

Downstream scoreboard stage for the small Moore machines under test. An upstream loader preloads a queue of expected (state, out) pairs. The checker observes the same step strobe that advances the FSM and compares the FSM's registered state and out against the queue head once per step. It reports per-step mismatch pulses, a saturating error count, the index of the first failing step, and a sticky underflow flag, so buggy variants (e.g. flipped output) are flagged cycle-accurately.

## Interface
- STATE_W, 3, width of FSM state
- DEPTH, 8, expected-entry queue depth (power of two, ≥2)
- CNT_W, 8, width of step/error counters

- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- exp_valid  in  1  expected entry offered
- exp_ready  out  1  queue can accept (= not full)
- exp_state  in  STATE_W  expected state after the step
- exp_out  in  1  expected out after the step
- step_in  in  1  same strobe driven to the FSM's ctrl_in
- dut_state  in  STATE_W  FSM state register
- dut_out  in  1  FSM out register
- mismatch  out  1  one-cycle pulse per failed compare
- err_count  out  CNT_W  saturating failed-compare count
- step_count  out  CNT_W  saturating completed-compare count
- first_err_idx  out  CNT_W  step_count value at first failure
- err_seen  out  1  sticky; first_err_idx valid
- underflow  out  1  sticky; step compared against empty queue
- halted  out  1  checker stopped (see Configuration)

## Operation
- Push: exp_valid && exp_ready at a rising edge writes {exp_state, exp_out} to the queue tail.
- Step capture: pending <= step_in every edge while not halted.
- Compare: at an edge with pending=1:
  - If the queue is non-empty, compare the head against dut_state/dut_out, pop, and increment step_count.
  - On inequality: pulse mismatch and increment err_count.
  - On the first failure: set err_seen and latch first_err_idx = pre-increment step_count.
- Empty at compare: set underflow. No pop, no count change, no mismatch.
- Push and pop in the same edge are both honoured. A push into an empty queue is not visible to a same-edge compare, so that case is an underflow.
- Full: exp_ready=0 and pushes are ignored. A same-edge pop does not reopen ready until the next cycle.
- Counters saturate at all-ones and never wrap. Queue pointers wrap modulo DEPTH.
- Control states:
  - IDLE (pending=0)
  - CMP (pending=1)
  - HALT (macro builds only)
  - Transitions: IDLE→CMP on step_in; CMP→CMP on step_in, else →IDLE; CMP→HALT on a failure when the macro is defined.

## Timing
- The FSM updates at edge T where ctrl_in=step_in=1. The checker compares at T+1 using values that are stable during the cycle (T, T+1].
- mismatch is high for the cycle following T+1. err_count and err_seen update at T+1.
- Back-to-back steps are supported: one compare per edge, throughput one step per cycle.
- Reset (any time, including mid-compare) forces the following, and flushes the queue:
  - pending=0, state IDLE
  - exp_ready=1
  - mismatch=0, err_count=0, step_count=0, first_err_idx=0
  - err_seen=0, underflow=0, halted=0
- The FSM's own reset does not touch the checker. The bench resets both together.

## Configuration
- STOP_ON_ERR_EN defined:
  - The first mismatch moves the control FSM to HALT.
  - halted=1 from the cycle after the failing compare.
  - Further step_in are ignored, exp_ready=0, and all counters freeze until reset.
- Not defined: HALT does not exist, halted is tied 0, and checking continues through errors.

## Structure
- Package fsm_check_pkg:
  - exp_entry_t packed struct {state[STATE_W], out}
  - chk_state_t enum {IDLE, CMP, HALT}
  - default widths
- One sub-module, fsm_exp_fifo: synchronous DEPTH-entry FIFO of exp_entry_t with full/empty and async active-low reset. The checker owns the compare, counters and control FSM.

## Test plan
- Load FSM state 0 and push (1,1), (1,1), (0,0). Drive sw_in 1,2,3 with step_in high for three cycles → mismatch never asserts, step_count=3, err_count=0.
- Same stimulus against the flipped-output FSM variant → mismatch pulses on each step, err_count=3, err_seen=1, first_err_idx=0.
- One step with an empty queue → underflow=1, step_count=0, err_count=0, mismatch=0.
- Push 8 entries → exp_ready=0. A ninth push is dropped. After one compare, exp_ready=1 the next cycle.
- STOP_ON_ERR_EN: fail at step 2 → halted=1, first_err_idx=2. Later steps leave step_count=3 and err_count=1.
- Drop reset_n during a compare cycle → all outputs return to reset values immediately, and the queue reads empty after release.
